// File: rtl/clock_manager.sv
// PLL bring-up sequencer: reset, lock qualification, timeout retry and loss-of-lock handling.
// Define PLL_RELOCK_EN for automatic recovery after loss of lock; otherwise the block latches FAULT.
module clock_manager #(
  parameter logic [3:0]  DIVR           = 4'd0,
  parameter logic [6:0]  DIVF           = 7'd55,
  parameter logic [2:0]  DIVQ           = 3'd5,
  parameter logic [2:0]  FILTER_RANGE   = 3'd1,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_HOLD      = 1024,
  parameter int unsigned TIMEOUT        = 65535
) (
  input  logic       clock_in,
  input  logic       reset,
  output logic       clock_out,
  output logic       locked,
  output logic       rst_out,
  output logic       fault,
  output logic [7:0] relock_count
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned RC_W  = 8;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    HOLD,
    RUN,
    FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             relock_inc_c;
  logic             pll_lock;
  logic             pll_resetb;
  logic             lock_meta, lock_s;

`ifdef SYNTHESIS
  SB_PLL40_CORE #(
    .FEEDBACK_PATH ("SIMPLE"),
    .DIVR          (DIVR),
    .DIVF          (DIVF),
    .DIVQ          (DIVQ),
    .FILTER_RANGE  (FILTER_RANGE)
  ) u_pll (
    .REFERENCECLK (clock_in),
    .PLLOUTCORE   (clock_out),
    .PLLOUTGLOBAL (),
    .LOCK         (pll_lock),
    .RESETB       (pll_resetb),
    .BYPASS       (1'b0)
  );
`else
  // Behavioural PLL: locks two reference cycles after RESETB rises, for any non-empty configuration.
  logic       cfg_ok;
  logic [1:0] lock_dly;

  assign cfg_ok = |{DIVR, DIVF, DIVQ, FILTER_RANGE};

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset)            lock_dly <= '0;
    else if (!pll_resetb) lock_dly <= '0;
    else                  lock_dly <= {lock_dly[0], cfg_ok};
  end

  assign pll_lock  = lock_dly[1];
  assign clock_out = clock_in & pll_resetb;
`endif

  // Two-flop synchroniser for the raw PLL lock.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_d      = state_q;
    relock_inc_c = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = HOLD;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = PLL_RST;
          relock_inc_c = 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s)                             state_d = WAIT_LOCK;
        else if (cnt_q == CNT_W'(LOCK_HOLD - 1)) state_d = RUN;
      end
      RUN: begin
        if (!lock_s) begin
`ifdef PLL_RELOCK_EN
          state_d      = PLL_RST;
          relock_inc_c = 1'b1;
`else
          state_d      = FAULT;
`endif
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = PLL_RST;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      relock_count <= '0;
      locked       <= 1'b0;
      rst_out      <= 1'b1;
      fault        <= 1'b0;
      pll_resetb   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)  cnt_q <= '0;
      else if (cnt_q != '1)    cnt_q <= cnt_q + CNT_W'(1);
      if (relock_inc_c && (relock_count != '1)) relock_count <= relock_count + RC_W'(1);
      locked     <= (state_d == RUN);
      rst_out    <= (state_d != RUN);
      fault      <= (state_d == FAULT);
      pll_resetb <= (state_d == WAIT_LOCK) || (state_d == HOLD) || (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_clock_manager.sv
// Directed bench for clock_manager with a forced PLL lock and a scoreboard of expected results.
module tb_clock_manager;

  localparam int unsigned RST_CYC  = 4;
  localparam int unsigned HOLD_CYC = 8;
  localparam int unsigned TMO_CYC  = 32;
  localparam int unsigned SYNC_CYC = 2;
  localparam int unsigned QUAL_CYC = SYNC_CYC + 1 + HOLD_CYC;
  localparam int          BOUND    = 200;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       clock_out;
  logic       locked;
  logic       rst_out;
  logic       fault;
  logic [7:0] relock_count;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  clock_manager #(
    .PLL_RST_CYCLES (RST_CYC),
    .LOCK_HOLD      (HOLD_CYC),
    .TIMEOUT        (TMO_CYC)
  ) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .clock_out    (clock_out),
    .locked       (locked),
    .rst_out      (rst_out),
    .fault        (fault),
    .relock_count (relock_count)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge clock_in);
      @(negedge clock_in);
    end
  endtask

  task automatic set_lock(input bit v);
    if (v) force dut.pll_lock = 1'b1;
    else   force dut.pll_lock = 1'b0;
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return dut.pll_resetb;
      1:       return locked;
      2:       return fault;
      default: return rst_out;
    endcase
  endfunction

  // Counts clock cycles until the probed signal reaches val; returns max if it never does.
  task automatic wait_for(input int sel, input logic val, input int max, output int n);
    n = 0;
    while ((probe(sel) !== val) && (n < max)) begin
      cycles(1);
      n++;
    end
  endtask

  initial begin
    int n;
    set_lock(1'b0);
    reset = 1'b1;
    cycles(3);

    // Reset state
    push("rst_locked", 0);      check(32'(locked));
    push("rst_rst_out", 1);     check(32'(rst_out));
    push("rst_fault", 0);       check(32'(fault));
    push("rst_relock", 0);      check(32'(relock_count));
    push("rst_resetb", 0);      check(32'(dut.pll_resetb));

    // Clean bring-up
    reset = 1'b0;
    push("bringup_resetb_cycles", RST_CYC);
    wait_for(0, 1'b1, BOUND, n); check(32'(n));
    cycles(2);
    set_lock(1'b1);
    push("bringup_lock_to_locked", QUAL_CYC);
    wait_for(1, 1'b1, BOUND, n); check(32'(n));
    push("run_rst_out", 0);     check(32'(rst_out));
    push("run_relock", 0);      check(32'(relock_count));
    push("run_fault", 0);       check(32'(fault));

    // Asynchronous reset in RUN acts before the next edge
    @(posedge clock_in);
    #2 reset = 1'b1;
    #1;
    push("async_rst_out", 1);   check(32'(rst_out));
    push("async_locked", 0);    check(32'(locked));
    push("async_relock", 0);    check(32'(relock_count));
    set_lock(1'b0);
    @(negedge clock_in);
    cycles(1);

    // Lock glitch during HOLD restarts qualification
    reset = 1'b0;
    push("glitch_resetb_cycles", RST_CYC);
    wait_for(0, 1'b1, BOUND, n); check(32'(n));
    set_lock(1'b1);
    cycles(6);
    set_lock(1'b0);
    cycles(1);
    set_lock(1'b1);
    push("glitch_requalify", QUAL_CYC);
    wait_for(1, 1'b1, BOUND, n); check(32'(n));
    push("glitch_relock", 0);   check(32'(relock_count));

    // Loss of lock in RUN
    set_lock(1'b0);
    push("loss_locked_low", SYNC_CYC + 1);
    wait_for(1, 1'b0, BOUND, n); check(32'(n));
`ifdef PLL_RELOCK_EN
    push("relock_count_one", 1); check(32'(relock_count));
    push("relock_resetb_low", 0); check(32'(dut.pll_resetb));
    push("relock_resetb_cycles", RST_CYC);
    wait_for(0, 1'b1, BOUND, n); check(32'(n));
    cycles(2);
    set_lock(1'b1);
    push("relock_lock_to_locked", QUAL_CYC);
    wait_for(1, 1'b1, BOUND, n); check(32'(n));
    push("relock_fault", 0);    check(32'(fault));
`else
    push("fault_set", 1);       check(32'(fault));
    push("fault_rst_out", 1);   check(32'(rst_out));
    push("fault_resetb", 0);    check(32'(dut.pll_resetb));
    push("fault_relock", 0);    check(32'(relock_count));
    set_lock(1'b1);
    cycles(20);
    push("fault_sticky", 1);    check(32'(fault));
    push("fault_locked", 0);    check(32'(locked));
    reset = 1'b1;
    #1;
    push("fault_cleared", 0);   check(32'(fault));
    push("fault_rst_resetb", 0); check(32'(dut.pll_resetb));
`endif

    // Lock never arrives: timeout retries and saturating count
    reset = 1'b1;
    set_lock(1'b0);
    @(negedge clock_in);
    cycles(2);
    reset = 1'b0;
    push("tmo_first_rise", RST_CYC);
    wait_for(0, 1'b1, BOUND, n); check(32'(n));
    for (int i = 1; i <= 3; i++) begin
      push("tmo_high_cycles", TMO_CYC);
      wait_for(0, 1'b0, BOUND, n); check(32'(n));
      push("tmo_relock_step", 32'(i)); check(32'(relock_count));
      push("tmo_low_cycles", RST_CYC);
      wait_for(0, 1'b1, BOUND, n); check(32'(n));
    end
    n = 0;
    while ((relock_count !== 8'd255) && (n < 12000)) begin
      cycles(1);
      n++;
    end
    push("tmo_reach_255", 255); check(32'(relock_count));
    cycles(3 * (RST_CYC + TMO_CYC));
    push("tmo_saturated", 255); check(32'(relock_count));
    push("tmo_locked", 0);      check(32'(locked));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
